// File: rtl/bin_blob_locator_if.sv
// Mask-stream input and per-frame result record of the blob locator.
interface bin_blob_locator_if #(
   parameter int X_W   = 10,
   parameter int CNT_W = 19
);
   logic             din_sop;
   logic             din_eop;
   logic             din_vld;
   logic             din;
   logic             res_vld;
   logic             found;
   logic [X_W-1:0]   cx;
   logic [X_W-1:0]   cy;
   logic [X_W-1:0]   x_min;
   logic [X_W-1:0]   x_max;
   logic [X_W-1:0]   y_min;
   logic [X_W-1:0]   y_max;
   logic [CNT_W-1:0] pix_cnt;
   logic             frame_drop;

   modport master (
      output din_sop, din_eop, din_vld, din,
      input  res_vld, found, cx, cy, x_min, x_max, y_min, y_max, pix_cnt, frame_drop
   );

   modport slave (
      input  din_sop, din_eop, din_vld, din,
      output res_vld, found, cx, cy, x_min, x_max, y_min, y_max, pix_cnt, frame_drop
   );
endinterface

// File: rtl/bin_blob_locator.sv
// Per-frame mask statistics (count, coordinate sums, bounding box) and a
// serial restoring divider that turns the sums into a centroid.
//
// state | meaning
// IDLE  | waiting for an accepted end of frame
// DIV_X | one quotient bit of sum_x / cnt per cycle
// DIV_Y | one quotient bit of sum_y / cnt per cycle
// DONE  | result record presented, res_vld high for this cycle
module bin_blob_locator #(
   parameter int H_ACT   = 640,
   parameter int V_ACT   = 480,
   parameter int X_W     = 10,
   parameter int CNT_W   = 19,
   parameter int SUM_W   = 29,
   parameter int MIN_PIX = 64
) (
   input  logic              clk,
   input  logic              rst,
   bin_blob_locator_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;
   localparam int BC_W = $clog2(SUM_W);

   state_t             state_q, state_d;
   logic [X_W-1:0]     x_q, y_q, x_cur, y_cur;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SUM_W-1:0]   sx_q, sx_d, sy_q, sy_d;
   logic [X_W-1:0]     xmn_q, xmn_d, xmx_q, xmx_d, ymn_q, ymn_d, ymx_q, ymx_d;
   logic [CNT_W-1:0]   snap_cnt_q;
   logic [SUM_W-1:0]   snap_sy_q;
   logic [X_W-1:0]     snap_xmn_q, snap_xmx_q, snap_ymn_q, snap_ymx_q;
   logic [SUM_W-1:0]   dvd_q, dvd_d, step_dvd;
   logic [CNT_W-1:0]   rem_q, rem_d, step_rem;
   logic [CNT_W:0]     rem_sh;
   logic               ge;
   logic [BC_W-1:0]    bc_q, bc_d;
   logic [X_W-1:0]     qx_q;
   logic               qx_ld, res_ld, res_vld;
   logic               accept, drop, found_w;
   logic               found_q, drop_q;
   logic [X_W-1:0]     cx_q, cy_q, xmn_o_q, xmx_o_q, ymn_o_q, ymx_o_q;
   logic [CNT_W-1:0]   pix_cnt_q;

   // An end of frame is only taken while the divider is free; otherwise dropped.
   assign accept  = bus.din_vld & bus.din_eop & (state_q == IDLE);
   assign drop    = bus.din_vld & bus.din_eop & (state_q != IDLE);
   assign found_w = snap_cnt_q >= CNT_W'(MIN_PIX);

   // Coordinate of the current beat: sop restarts at origin, x wraps, y saturates.
   always_comb begin
      x_cur = '0;
      y_cur = '0;
      if (!bus.din_sop) begin
         if (x_q == X_W'(H_ACT - 1)) begin
            x_cur = '0;
            y_cur = (y_q == X_W'(V_ACT - 1)) ? y_q : y_q + 1'b1;
         end else begin
            x_cur = x_q + 1'b1;
            y_cur = y_q;
         end
      end
   end

   // Accumulator next values; a sop beat clears first, then adds its own pixel.
   always_comb begin
      cnt_d = bus.din_sop ? '0 : cnt_q;
      sx_d  = bus.din_sop ? '0 : sx_q;
      sy_d  = bus.din_sop ? '0 : sy_q;
      xmn_d = bus.din_sop ? '1 : xmn_q;
      xmx_d = bus.din_sop ? '0 : xmx_q;
      ymn_d = bus.din_sop ? '1 : ymn_q;
      ymx_d = bus.din_sop ? '0 : ymx_q;
      if (bus.din) begin
         cnt_d = cnt_d + 1'b1;
         sx_d  = sx_d + SUM_W'(x_cur);
         sy_d  = sy_d + SUM_W'(y_cur);
         if (x_cur < xmn_d) xmn_d = x_cur;
         if (x_cur > xmx_d) xmx_d = x_cur;
         if (y_cur < ymn_d) ymn_d = y_cur;
         if (y_cur > ymx_d) ymx_d = y_cur;
      end
   end

   // Coordinate counters and accumulators advance only on valid beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q   <= '0;
         y_q   <= '0;
         cnt_q <= '0;
         sx_q  <= '0;
         sy_q  <= '0;
         xmn_q <= '1;
         xmx_q <= '0;
         ymn_q <= '1;
         ymx_q <= '0;
      end else if (bus.din_vld) begin
         x_q   <= x_cur;
         y_q   <= y_cur;
         cnt_q <= cnt_d;
         sx_q  <= sx_d;
         sy_q  <= sy_d;
         xmn_q <= xmn_d;
         xmx_q <= xmx_d;
         ymn_q <= ymn_d;
         ymx_q <= ymx_d;
      end
   end

   // Snapshot of the finished frame, so accumulation of the next one can proceed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_cnt_q <= '0;
         snap_sy_q  <= '0;
         snap_xmn_q <= '0;
         snap_xmx_q <= '0;
         snap_ymn_q <= '0;
         snap_ymx_q <= '0;
      end else if (accept) begin
         snap_cnt_q <= cnt_d;
         snap_sy_q  <= sy_d;
         snap_xmn_q <= xmn_d;
         snap_xmx_q <= xmx_d;
         snap_ymn_q <= ymn_d;
         snap_ymx_q <= ymx_d;
      end
   end

   // One restoring-division step; a zero divisor yields all-ones, never X.
   always_comb begin
      rem_sh   = {rem_q, dvd_q[SUM_W-1]};
      ge       = rem_sh >= {1'b0, snap_cnt_q};
      step_rem = ge ? (rem_sh[CNT_W-1:0] - snap_cnt_q) : rem_sh[CNT_W-1:0];
      step_dvd = {dvd_q[SUM_W-2:0], ge};
   end

   // Divider sequencing: next state, datapath loads and the result strobe.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      bc_d    = bc_q;
      qx_ld   = 1'b0;
      res_ld  = 1'b0;
      res_vld = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = DIV_X;
               dvd_d   = sx_d;
               rem_d   = '0;
               bc_d    = BC_W'(SUM_W - 1);
            end
         end
         DIV_X: begin
            dvd_d = step_dvd;
            rem_d = step_rem;
            bc_d  = bc_q - 1'b1;
            if (bc_q == '0) begin
               state_d = DIV_Y;
               qx_ld   = 1'b1;
               dvd_d   = snap_sy_q;
               rem_d   = '0;
               bc_d    = BC_W'(SUM_W - 1);
            end
         end
         DIV_Y: begin
            dvd_d = step_dvd;
            rem_d = step_rem;
            bc_d  = bc_q - 1'b1;
            if (bc_q == '0) begin
               state_d = DONE;
               res_ld  = 1'b1;
            end
         end
         DONE: begin
            res_vld = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and divider registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         rem_q   <= '0;
         bc_q    <= '0;
         qx_q    <= '0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         bc_q    <= bc_d;
         if (qx_ld) qx_q <= step_dvd[X_W-1:0];
      end
   end

   // Result record, held between pulses; forced to zero below the pixel threshold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         found_q   <= 1'b0;
         cx_q      <= '0;
         cy_q      <= '0;
         xmn_o_q   <= '0;
         xmx_o_q   <= '0;
         ymn_o_q   <= '0;
         ymx_o_q   <= '0;
         pix_cnt_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         drop_q <= drop;
         if (res_ld) begin
            found_q   <= found_w;
            pix_cnt_q <= snap_cnt_q;
            cx_q      <= found_w ? qx_q : '0;
            cy_q      <= found_w ? step_dvd[X_W-1:0] : '0;
            xmn_o_q   <= found_w ? snap_xmn_q : '0;
            xmx_o_q   <= found_w ? snap_xmx_q : '0;
            ymn_o_q   <= found_w ? snap_ymn_q : '0;
            ymx_o_q   <= found_w ? snap_ymx_q : '0;
         end
      end
   end

   assign bus.res_vld    = res_vld;
   assign bus.found      = found_q;
   assign bus.cx         = cx_q;
   assign bus.cy         = cy_q;
   assign bus.x_min      = xmn_o_q;
   assign bus.x_max      = xmx_o_q;
   assign bus.y_min      = ymn_o_q;
   assign bus.y_max      = ymx_o_q;
   assign bus.pix_cnt    = pix_cnt_q;
   assign bus.frame_drop = drop_q;
endmodule

// File: tb/tb_bin_blob_locator.sv
// Bench for bin_blob_locator: directed frames plus random frames, all checked
// every cycle against a frame-level reference model.
module tb_bin_blob_locator;
   localparam int H_ACT   = 8;
   localparam int V_ACT   = 4;
   localparam int X_W     = 10;
   localparam int CNT_W   = 19;
   localparam int SUM_W   = 29;
   localparam int MIN_PIX = 1;
   localparam int LAT     = 2 * SUM_W + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bin_blob_locator_if #(.X_W(X_W), .CNT_W(CNT_W)) bus ();

   bin_blob_locator #(
      .H_ACT(H_ACT), .V_ACT(V_ACT), .X_W(X_W), .CNT_W(CNT_W),
      .SUM_W(SUM_W), .MIN_PIX(MIN_PIX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               due;
      logic             found;
      logic [X_W-1:0]   cx, cy, xmn, xmx, ymn, ymx;
      logic [CNT_W-1:0] cnt;
   } rec_t;

   rec_t rq[$];
   int   dq[$];
   rec_t last, last_model;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   busy_until = -1000;
   int   last_eop = 0;
   int   n_drop = 0;
   int   n_acc = 0;
   bit   pix[64];
   bit   exp_res, exp_drop;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic rec_t zero_rec();
      rec_t r;
      r.due = 0; r.found = 1'b0; r.cnt = '0;
      r.cx = '0; r.cy = '0; r.xmn = '0; r.xmx = '0; r.ymn = '0; r.ymx = '0;
      return r;
   endfunction

   // Frame statistics straight from raster position: x = i mod H, y = min(i div H, V-1).
   function automatic rec_t model(int nb);
      rec_t r;
      int cnt = 0, sx = 0, sy = 0, xmn = 1 << 20, xmx = -1, ymn = 1 << 20, ymx = -1;
      for (int i = 0; i < nb; i++) begin
         int x, y;
         x = i % H_ACT;
         y = i / H_ACT;
         if (y > V_ACT - 1) y = V_ACT - 1;
         if (pix[i]) begin
            cnt++; sx += x; sy += y;
            if (x < xmn) xmn = x;
            if (x > xmx) xmx = x;
            if (y < ymn) ymn = y;
            if (y > ymx) ymx = y;
         end
      end
      r = zero_rec();
      r.cnt   = CNT_W'(cnt);
      r.found = (cnt >= MIN_PIX);
      if (r.found) begin
         r.cx  = X_W'(sx / cnt);
         r.cy  = X_W'(sy / cnt);
         r.xmn = X_W'(xmn); r.xmx = X_W'(xmx);
         r.ymn = X_W'(ymn); r.ymx = X_W'(ymx);
      end
      return r;
   endfunction

   // The divider is busy for LAT cycles after an accepted end of frame.
   task automatic model_eop(input int e, input int nb);
      rec_t r;
      last_eop = e;
      if (e > busy_until) begin
         r = model(nb);
         r.due = e + LAT;
         rq.push_back(r);
         last_model = r;
         busy_until = e + LAT;
         n_acc++;
      end else begin
         dq.push_back(e + 1);
         n_drop++;
      end
   endtask

   task automatic pin(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         bus.din_vld = 1'b0;
         bus.din_sop = 1'($urandom_range(0, 1));
         bus.din_eop = 1'($urandom_range(0, 1));
         bus.din     = 1'($urandom_range(0, 1));
         tick();
      end
      bus.din_sop = 1'b0; bus.din_eop = 1'b0; bus.din = 1'b0;
   endtask

   task automatic run_frame(input int nb, input bit with_eop, input int gap_pct);
      for (int i = 0; i < nb; i++) begin
         while (int'($urandom_range(0, 99)) < gap_pct) idle(1);
         bus.din_vld = 1'b1;
         bus.din_sop = (i == 0);
         bus.din_eop = with_eop && (i == nb - 1);
         bus.din     = pix[i];
         if (bus.din_eop) model_eop(cyc, nb);
         tick();
      end
      bus.din_vld = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0; bus.din = 1'b0;
   endtask

   task automatic clear_pix();
      for (int i = 0; i < 64; i++) pix[i] = 1'b0;
   endtask

   task automatic set_px(input int x, input int y);
      pix[y * H_ACT + x] = 1'b1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) idle(1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rq.delete();
      dq.delete();
      last = zero_rec();
      busy_until = -1000;
      idle(3);
      rst = 1'b0;
   endtask

   // Every cycle: strobes against model timing, record fields against the last reported frame.
   always @(negedge clk) begin
      exp_res  = (rq.size() > 0) && (rq[0].due == cyc);
      if (exp_res) last = rq.pop_front();
      exp_drop = (dq.size() > 0) && (dq[0] == cyc);
      if (exp_drop) void'(dq.pop_front());
      checks++;
      if (bus.res_vld !== exp_res) begin
         failures++;
         $display("FAIL res_vld cyc=%0d: got %b expected %b", cyc, bus.res_vld, exp_res);
      end
      checks++;
      if (bus.frame_drop !== exp_drop) begin
         failures++;
         $display("FAIL frame_drop cyc=%0d: got %b expected %b", cyc, bus.frame_drop, exp_drop);
      end
      checks++;
      if ({bus.found, bus.pix_cnt, bus.cx, bus.cy, bus.x_min, bus.x_max, bus.y_min, bus.y_max} !==
          {last.found, last.cnt, last.cx, last.cy, last.xmn, last.xmx, last.ymn, last.ymx}) begin
         failures++;
         $display("FAIL result cyc=%0d: got found=%b cnt=%0d c=(%0d,%0d) box=%0d..%0d/%0d..%0d expected found=%b cnt=%0d c=(%0d,%0d) box=%0d..%0d/%0d..%0d",
                  cyc, bus.found, bus.pix_cnt, bus.cx, bus.cy, bus.x_min, bus.x_max, bus.y_min, bus.y_max,
                  last.found, last.cnt, last.cx, last.cy, last.xmn, last.xmx, last.ymn, last.ymx);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, a0, nb;
      last = zero_rec();
      last_model = zero_rec();
      bus.din_vld = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0; bus.din = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Square blob
      clear_pix();
      set_px(2, 1); set_px(3, 1); set_px(2, 2); set_px(3, 2);
      run_frame(32, 1'b1, 0);
      pin("t1_cnt", int'(last_model.cnt), 4);
      pin("t1_cx", int'(last_model.cx), 2);
      pin("t1_cy", int'(last_model.cy), 1);
      pin("t1_box", int'({last_model.xmn, last_model.xmx, last_model.ymn, last_model.ymx}),
          int'({10'd2, 10'd3, 10'd1, 10'd2}));
      idle(LAT + 5);

      // Corners
      clear_pix();
      set_px(0, 0); set_px(7, 3); set_px(7, 0);
      run_frame(32, 1'b1, 0);
      pin("t2_cnt", int'(last_model.cnt), 3);
      pin("t2_cx", int'(last_model.cx), 4);
      pin("t2_cy", int'(last_model.cy), 1);
      pin("t2_xmax", int'(last_model.xmx), 7);
      pin("t2_ymax", int'(last_model.ymx), 3);
      idle(LAT + 5);

      // Empty frame
      clear_pix();
      run_frame(32, 1'b1, 0);
      pin("t3_found", int'(last_model.found), 0);
      idle(LAT + 5);

      // Back-to-back: second eop lands in DIV_X and is dropped
      clear_pix();
      set_px(1, 1); set_px(5, 2);
      d0 = n_drop; a0 = n_acc;
      run_frame(32, 1'b1, 0);
      idle(10);
      run_frame(16, 1'b1, 0);
      pin("b2b_drops", n_drop - d0, 1);
      pin("b2b_accepts", n_acc - a0, 1);
      idle(100);
      clear_pix();
      set_px(6, 3); set_px(6, 1);
      run_frame(32, 1'b1, 0);
      pin("b2b_third_cy", int'(last_model.cy), 2);
      idle(LAT + 5);

      // Mid-frame sop discards earlier beats
      clear_pix();
      for (int i = 0; i < 5; i++) pix[i] = 1'b1;
      run_frame(5, 1'b0, 0);
      clear_pix();
      set_px(4, 2);
      run_frame(32, 1'b1, 0);
      pin("msop_cnt", int'(last_model.cnt), 1);
      pin("msop_cx", int'(last_model.cx), 4);
      pin("msop_cy", int'(last_model.cy), 2);
      idle(LAT + 5);

      // eop in DONE is dropped, the one right after is accepted
      clear_pix();
      pix[0] = 1'b1;
      run_frame(1, 1'b1, 0);
      wait_until(last_eop + LAT);
      d0 = n_drop; a0 = n_acc;
      run_frame(1, 1'b1, 0);
      run_frame(1, 1'b1, 0);
      pin("done_drop", n_drop - d0, 1);
      pin("done_accept", n_acc - a0, 1);
      idle(LAT + 5);

      // Reset during DIV_Y, then a frame with vld gaps
      clear_pix();
      set_px(3, 3);
      run_frame(32, 1'b1, 0);
      wait_until(last_eop + SUM_W + 10);
      do_reset();
      idle(LAT + 5);
      clear_pix();
      set_px(5, 0); set_px(2, 3); set_px(7, 2);
      run_frame(32, 1'b1, 40);
      idle(LAT + 5);

      // Random frames: lengths past the last line, gaps, missing eops, overruns
      for (int f = 0; f < 40; f++) begin
         int dens;
         nb = ($urandom_range(0, 9) == 0) ? 1 : int'($urandom_range(20, 40));
         dens = $urandom_range(0, 100);
         for (int i = 0; i < 64; i++) pix[i] = (int'($urandom_range(0, 99)) < dens);
         run_frame(nb, $urandom_range(0, 9) != 0, $urandom_range(0, 30));
         idle($urandom_range(0, 80));
      end

      idle(LAT + 10);
      pin("queues_drained", rq.size() + dq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
